axis_cpu_cmd_master: RTL
========================

Name: axis_cpu_cmd_master

Overview:
- Host-side driver for the axis_cpu programming ring: the other end of the cmd_in/cmd_out interface.
- Accepts a backpressured AXI-Stream of command words from the host and issues them as cmd words into the ring, which has no backpressure.
- Matches read responses returned on the ring and delivers them on a backpressured response stream.
- Sits between the host DMA/FIFO and the first axis_cpu cmd_in; the last cmd_out in the chain returns to this block.

Parameters:
- CPU_ID_WIDTH, 12, width of the target ID field in a command word; fixed at bits [29:18].
- TIMEOUT, 255, cycles to wait for a read response before giving up; 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- prog_TDATA  in  32  host command word
- prog_TVALID  in  1  host word valid
- prog_TREADY  out  1  block accepts host word
- prog_TLAST  in  1  last word of a host program
- ring_out_TDATA  out  32  cmd word to first CPU cmd_in
- ring_out_TVALID  out  1  cmd word valid; no ready
- ring_in_TDATA  in  32  word from last CPU cmd_out
- ring_in_TVALID  in  1  ring word valid; no ready
- resp_TDATA  out  32  read data to host
- resp_TVALID  out  1  response valid
- resp_TREADY  in  1  host accepts response
- resp_TUSER  out  1  1 = timeout, data invalid
- busy  out  1  high whenever the state is not IDLE
- prog_done  out  1  one-cycle pulse after the TLAST word has been fully issued

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Outputs in reset: all outputs 0; state IDLE; timeout counter 0.
- Command word op field, bits [31:30]:
  - 00 = NOP: consumed, never forwarded.
  - 01 = WR: header word, and the next prog word is its data word.
  - 10 = RD: single header word, then wait for a response.
  - 11 = RAW: forwarded as-is with no wait.
- Target ID is bits [29:18].
- States:
  - IDLE: prog_TREADY=1. On a prog handshake: NOP does not change state; WR goes to WDATA; RD goes to WAIT; RAW stays in IDLE.
  - WDATA: prog_TREADY=1. On a handshake, forward the data word and return to IDLE.
  - WAIT: prog_TREADY=0. Wait for the response header on the ring, then go to RDATA.
  - RDATA: prog_TREADY=0. The next ring_in valid word is the data; load it into the resp register and go to RESP.
  - RESP: prog_TREADY=0. resp_TVALID=1 and is held stable until resp_TREADY; on the handshake go to IDLE.
- Issue latency: a prog word accepted in cycle N appears on ring_out (registered) with TVALID=1 in cycle N+1 for exactly one cycle. Back-to-back accepted words give back-to-back ring words.
- Response match: a ring_in word matches only if ring_in_TVALID=1, bits [31:30]=10, and bits [29:18] equal the latched pending ID. Every other ring_in word is ignored in every state, including unsolicited and late ones.
- Timeout: the counter clears on entering WAIT and increments each cycle spent in WAIT or RDATA. When it reaches TIMEOUT, load resp_TDATA=32'hDEADBEEF and resp_TUSER=1, go to RESP, and ignore any later response for that read.
- TLAST handling: a TLAST word's op completes first, including the read response handshake. prog_done then pulses in the cycle the block returns to IDLE.
- WR header arriving with TLAST (malformed): forward the header, emit data word 32'h0 on the next cycle, return to IDLE, and pulse prog_done.
- Simultaneous response match and timeout expiry in the same cycle: the match wins.
- Reset mid-operation: any pending read is discarded and ring_out_TVALID drops immediately. Responses arriving after reset release are ignored.

Optional Feature:
- Macro: CMD_MASTER_ERRCNT_EN.
- Defined: adds output err_count (16 bits). It increments on each timeout, saturates at 16'hFFFF, and is cleared only by rst.
- Undefined: the port is absent and there is no counter logic.

Test Plan:
- WR stream: prog words 0x40000005, 0x12345678 (TLAST) with TVALID continuously high -> ring_out carries 0x40000005 then 0x12345678 in consecutive cycles starting one cycle after acceptance; prog_done pulses once; busy returns to 0.
- RD: prog 0x80040000 (ID=1); ring returns 0x80040000, then 0xCAFEF00D three cycles later -> resp_TDATA=0xCAFEF00D with resp_TUSER=0; prog_TREADY stays 0 until the resp handshake.
- RD with resp_TREADY held 0 for 10 cycles -> resp_TVALID and resp_TDATA stay stable throughout, and no new prog word is accepted.
- RD with no response and TIMEOUT=8 -> after 8 cycles resp=0xDEADBEEF with resp_TUSER=1; a response injected later is ignored; err_count=1 when CMD_MASTER_ERRCNT_EN is defined.
- Mismatched ring word 0x80080000 (ID=2) while waiting on ID=1 -> ignored; the following correct ID=1 header plus data completes normally.
- Reset asserted in WAIT -> all outputs go to 0 asynchronously; after release, the next NOP then RAW 0xC0000001 produces only the RAW word on ring_out.

Source files
------------

// File: rtl/axis_cpu_cmd_master.sv
// Host-side master of the axis_cpu command ring: issues host commands, matches read responses.
// Optional macro CMD_MASTER_ERRCNT_EN adds a saturating timeout counter on output err_count.
module axis_cpu_cmd_master #(
  parameter int CPU_ID_WIDTH = 12,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] prog_TDATA,
  input  logic        prog_TVALID,
  output logic        prog_TREADY,
  input  logic        prog_TLAST,
  output logic [31:0] ring_out_TDATA,
  output logic        ring_out_TVALID,
  input  logic [31:0] ring_in_TDATA,
  input  logic        ring_in_TVALID,
  output logic [31:0] resp_TDATA,
  output logic        resp_TVALID,
  input  logic        resp_TREADY,
  output logic        resp_TUSER,
`ifdef CMD_MASTER_ERRCNT_EN
  output logic [15:0] err_count,
`endif
  output logic        busy,
  output logic        prog_done
);
  localparam int          ID_LSB   = 18;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WZERO, S_WAIT, S_RDATA, S_RESP} state_t;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_WR = 2'b01, OP_RD = 2'b10, OP_RAW = 2'b11} op_t;

  state_t                  r_state, w_next;
  logic                    r_run;
  logic                    r_last;
  logic [CPU_ID_WIDTH-1:0] r_pend_id;
  logic [15:0]             r_cnt;
  logic [31:0]             r_out_data;
  logic                    r_out_vld;
  logic [31:0]             r_resp_data;
  logic                    r_resp_user;
  logic                    r_done;

  op_t         w_op;
  logic        w_hs;
  logic        w_hdr_match;
  logic        w_expired;
  logic        w_issue;
  logic [31:0] w_issue_data;
  logic        w_done;
  logic        w_start_rd;
  logic        w_load_resp;
  logic [31:0] w_resp_data;
  logic        w_resp_user;
  logic        w_timeout;

  assign w_op        = op_t'(prog_TDATA[31:30]);
  // r_run keeps TREADY low while reset is held and for the first edge after release
  assign prog_TREADY = r_run && (r_state == S_IDLE || r_state == S_WDATA);
  assign w_hs        = prog_TVALID && prog_TREADY;
  assign w_hdr_match = ring_in_TVALID && (ring_in_TDATA[31:30] == 2'b10) &&
                       (ring_in_TDATA[ID_LSB +: CPU_ID_WIDTH] == r_pend_id);
  assign w_expired   = (r_cnt >= CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_issue      = 1'b0;
    w_issue_data = prog_TDATA;
    w_done       = 1'b0;
    w_start_rd   = 1'b0;
    w_load_resp  = 1'b0;
    w_resp_data  = ring_in_TDATA;
    w_resp_user  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          case (w_op)
            OP_NOP: w_done = prog_TLAST;
            OP_WR: begin
              w_issue = 1'b1;
              // a WR header carrying TLAST has no data word coming; pad with zero
              w_next  = prog_TLAST ? S_WZERO : S_WDATA;
            end
            OP_RD: begin
              w_issue    = 1'b1;
              w_start_rd = 1'b1;
              w_next     = S_WAIT;
            end
            default: begin
              w_issue = 1'b1;
              w_done  = prog_TLAST;
            end
          endcase
        end
      end
      S_WDATA: begin
        if (w_hs) begin
          w_issue = 1'b1;
          w_done  = prog_TLAST;
          w_next  = S_IDLE;
        end
      end
      S_WZERO: begin
        w_issue      = 1'b1;
        w_issue_data = 32'h0;
        w_done       = 1'b1;
        w_next       = S_IDLE;
      end
      S_WAIT: begin
        if (w_hdr_match)    w_next    = S_RDATA;
        else if (w_expired) w_timeout = 1'b1;
      end
      S_RDATA: begin
        if (ring_in_TVALID) begin
          w_load_resp = 1'b1;
          w_next      = S_RESP;
        end else if (w_expired) begin
          w_timeout = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_TREADY) begin
          w_done = r_last;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_timeout) begin
      w_load_resp = 1'b1;
      w_resp_data = 32'hDEADBEEF;
      w_resp_user = 1'b1;
      w_next      = S_RESP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run       <= 1'b0;
      r_last      <= 1'b0;
      r_pend_id   <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_vld   <= 1'b0;
      r_resp_data <= '0;
      r_resp_user <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_run     <= 1'b1;
      r_out_vld <= w_issue;
      r_done    <= w_done;
      if (w_issue) r_out_data <= w_issue_data;
      if (w_start_rd) begin
        r_pend_id <= prog_TDATA[ID_LSB +: CPU_ID_WIDTH];
        r_last    <= prog_TLAST;
        r_cnt     <= '0;
      end else if (r_state == S_WAIT || r_state == S_RDATA) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_load_resp) begin
        r_resp_data <= w_resp_data;
        r_resp_user <= w_resp_user;
      end
    end
  end

`ifdef CMD_MASTER_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_err_cnt <= '0;
    else if (w_timeout && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign err_count = r_err_cnt;
`endif

  assign ring_out_TDATA  = r_out_data;
  assign ring_out_TVALID = r_out_vld;
  assign resp_TDATA      = r_resp_data;
  assign resp_TUSER      = r_resp_user;
  assign resp_TVALID     = (r_state == S_RESP);
  assign busy            = (r_state != S_IDLE);
  assign prog_done       = r_done;
endmodule
